// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM scheduler: command codes, burst-owner
// states and the framebuffer geometry defaults.
package sdram_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WR256 = 2'b01;
  localparam logic [1:0] CMD_RDVID = 2'b10;
  localparam logic [1:0] CMD_RD256 = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_VID   = 2'd1,
    OWN_CACHE = 2'd2
  } owner_e;

  localparam logic [14:0] VID_BASE_DEF   = 15'h6FF8;
  localparam int          VID_BLOCKS_DEF = 3072;

endpackage

// File: rtl/sdram_sched_vid_packer.sv
// Pairs returned 16-bit halfwords into 32-bit video queue words, low half
// first; clr discards any half-assembled pair.
module vid_packer
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        valid,
  input  logic [15:0] din,
  output logic [31:0] vq_data,
  output logic        vq_we
);

  logic        pack_phase;
  logic [15:0] low_half;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_phase <= 1'b0;
      low_half   <= '0;
      vq_data    <= '0;
      vq_we      <= 1'b0;
    end else begin
      vq_we <= valid && pack_phase;
      if (valid && !pack_phase)
        low_half <= din;
      if (valid && pack_phase)
        vq_data <= {din, low_half};
      // A beat arriving with clr still belongs to the old burst; clr only
      // forbids carrying a split pair into the next one.
      if (clr)
        pack_phase <= 1'b0;
      else if (valid)
        pack_phase <= ~pack_phase;
    end
  end

endmodule

// File: rtl/sdram_sched.sv
// SDRAM command scheduler: fixed-priority arbitration, burst ownership
// tracking, return-data steering and framebuffer block counter.
module sdram_sched
  import sdram_pkg::*;
#(
  parameter logic [14:0] VID_BASE   = VID_BASE_DEF,
  parameter int          VID_BLOCKS = VID_BLOCKS_DEF
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_low,
  input  logic        cache_wr_req,
  input  logic        cache_rd_req,
  input  logic [11:0] cache_waddr,
  input  logic [11:0] cache_raddr,
  output logic [1:0]  sys_cmd,
  output logic [17:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_fill_we,
  output logic        cache_drain_re,
  output logic [31:0] vq_data,
  output logic        vq_we,
  output logic [11:0] vid_idx
);

  owner_e      state, state_nxt;
  logic        ack_idle;
  logic        accept;
  logic        vid_valid;
  logic [14:0] vid_off;
  logic [14:0] vid_blk;

  always_ff @(posedge clk) begin
    if (rst) begin
      sys_cmd  <= CMD_NOP;
      ack_idle <= 1'b1;
    end else begin
      ack_idle <= (sys_cmd_ack == 2'b00);
      if (vid_low)           sys_cmd <= CMD_RDVID;
      else if (cache_wr_req) sys_cmd <= CMD_WR256;
      else if (cache_rd_req) sys_cmd <= CMD_RD256;
      else                   sys_cmd <= CMD_NOP;
    end
  end

  // Only the first cycle of a nonzero ack run counts as an accept.
  assign accept = ack_idle && (sys_cmd_ack != 2'b00);

  // Framebuffer is stored bottom-up, so the line part of the index is inverted.
  assign vid_off = {3'b000, ~vid_idx[11:2], vid_idx[1:0]};
  assign vid_blk = VID_BASE + vid_off;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    sys_addr = '0;
    case (sys_cmd)
      CMD_WR256: sys_addr = {cache_waddr, 6'b000000};
      CMD_RD256: sys_addr = {cache_raddr, 6'b000000};
      CMD_RDVID: sys_addr = {vid_blk, 3'b000};
      default:   sys_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= OWN_NONE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = (sys_cmd_ack == CMD_RDVID) ? OWN_VID : OWN_CACHE;
  end

  // Steering uses the registered owner, so a strobe coincident with an
  // accept still goes to the previous owner.
  always_comb begin
    cache_fill_we  = (state == OWN_CACHE) && sys_rd_data_valid;
    cache_drain_re = (state == OWN_CACHE) && sys_wr_data_valid;
    vid_valid      = (state == OWN_VID)   && sys_rd_data_valid;
  end

  always_ff @(posedge clk) begin
    if (rst)
      vid_idx <= '0;
    else if (accept && sys_cmd_ack == CMD_RDVID)
      vid_idx <= (vid_idx == 12'(VID_BLOCKS - 1)) ? 12'd0 : vid_idx + 12'd1;
  end

  vid_packer u_vid_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .valid   (vid_valid),
    .din     (sys_dout),
    .vq_data (vq_data),
    .vq_we   (vq_we)
  );

endmodule

// File: tb/tb_sdram_sched.sv
// Directed bench for sdram_sched: arbitration table plus hand-written
// burst, wrap, cache-fill and mid-burst-reset sequences.
module tb_sdram_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_low, cache_wr_req, cache_rd_req;
  logic [11:0] cache_waddr, cache_raddr;
  logic [1:0]  sys_cmd;
  logic [17:0] sys_addr;
  logic [1:0]  sys_cmd_ack;
  logic        sys_rd_data_valid, sys_wr_data_valid;
  logic [15:0] sys_dout;
  logic        cache_fill_we, cache_drain_re;
  logic [31:0] vq_data;
  logic        vq_we;
  logic [11:0] vid_idx;

  int checks = 0;
  int failures = 0;

  int          vq_cnt = 0;
  int          fill_cnt = 0;
  int          drain_cnt = 0;
  logic [31:0] vq_log [0:63];

  always #5 clk = ~clk;

  sdram_sched dut (
    .clk               (clk),
    .rst               (rst),
    .vid_low           (vid_low),
    .cache_wr_req      (cache_wr_req),
    .cache_rd_req      (cache_rd_req),
    .cache_waddr       (cache_waddr),
    .cache_raddr       (cache_raddr),
    .sys_cmd           (sys_cmd),
    .sys_addr          (sys_addr),
    .sys_cmd_ack       (sys_cmd_ack),
    .sys_rd_data_valid (sys_rd_data_valid),
    .sys_wr_data_valid (sys_wr_data_valid),
    .sys_dout          (sys_dout),
    .cache_fill_we     (cache_fill_we),
    .cache_drain_re    (cache_drain_re),
    .vq_data           (vq_data),
    .vq_we             (vq_we),
    .vid_idx           (vid_idx)
  );

  // Output monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (vq_we) begin
      if (vq_cnt < 64) vq_log[vq_cnt] = vq_data;
      vq_cnt++;
    end
    if (cache_fill_we)  fill_cnt++;
    if (cache_drain_re) drain_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse an ack code for `hold` cycles, then return to idle for one cycle.
  task automatic do_ack(input logic [1:0] code, input int hold);
    sys_cmd_ack = code;
    repeat (hold) tick();
    sys_cmd_ack = 2'b00;
    tick();
  endtask

  typedef struct {
    logic        vl, wr, rd;
    logic [11:0] waddr, raddr;
    logic [1:0]  exp_cmd;
    logic [17:0] exp_addr;
  } arb_vec_t;

  arb_vec_t vecs [0:6];

  int base_vq, base_fill, base_drain;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 12'hA5A, 12'h3C3, 2'b10, 18'h3FFA0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 12'hA5A, 12'h3C3, 2'b01, 18'h29680};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 12'hA5A, 12'h3C3, 2'b11, 18'h0F0C0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 12'hA5A, 12'h3C3, 2'b00, 18'h00000};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 12'hFFF, 12'h000, 2'b01, 18'h3FFC0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 12'hFFF, 12'h001, 2'b10, 18'h3FFA0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 12'hFFF, 12'h001, 2'b11, 18'h00040};

    rst = 1'b1;
    vid_low = 0; cache_wr_req = 0; cache_rd_req = 0;
    cache_waddr = '0; cache_raddr = '0;
    sys_cmd_ack = 2'b00;
    sys_rd_data_valid = 0; sys_wr_data_valid = 0; sys_dout = '0;

    // Reset
    repeat (2) tick();
    rst = 1'b0;
    check("rst_sys_cmd", 32'(sys_cmd), 32'h0);
    check("rst_vid_idx", 32'(vid_idx), 32'h0);
    check("rst_vq_we", 32'(vq_we), 32'h0);
    check("rst_vq_data", vq_data, 32'h0);
    check("rst_sys_addr", 32'(sys_addr), 32'h0);

    // Arbitration table
    for (int i = 0; i < 7; i++) begin
      vid_low = vecs[i].vl; cache_wr_req = vecs[i].wr; cache_rd_req = vecs[i].rd;
      cache_waddr = vecs[i].waddr; cache_raddr = vecs[i].raddr;
      tick();
      check($sformatf("arb%0d_cmd", i), 32'(sys_cmd), 32'(vecs[i].exp_cmd));
      check($sformatf("arb%0d_addr", i), 32'(sys_addr), 32'(vecs[i].exp_addr));
    end
    vid_low = 0; cache_wr_req = 0; cache_rd_req = 0;
    tick();

    // Owner NONE: data strobes go nowhere
    base_vq = vq_cnt; base_fill = fill_cnt;
    sys_rd_data_valid = 1; sys_dout = 16'hBEEF;
    #1 check("none_fill_we", 32'(cache_fill_we), 32'h0);
    repeat (2) tick();
    sys_rd_data_valid = 0;
    repeat (2) tick();
    check("none_vq_cnt", 32'(vq_cnt - base_vq), 32'h0);

    // Video burst: 16 halfwords -> 8 packed words
    do_ack(2'b10, 1);
    check("burst_vid_idx", 32'(vid_idx), 32'h1);
    base_vq = vq_cnt;
    for (int i = 1; i <= 16; i++) begin
      sys_rd_data_valid = 1; sys_dout = 16'(i);
      #1 check($sformatf("vid_fill_we%0d", i), 32'(cache_fill_we), 32'h0);
      tick();
    end
    sys_rd_data_valid = 0;
    repeat (2) tick();
    check("burst_vq_cnt", 32'(vq_cnt - base_vq), 32'd8);
    for (int k = 0; k < 8; k++)
      check($sformatf("burst_word%0d", k), vq_log[base_vq + k],
            {16'(2 * k + 2), 16'(2 * k + 1)});

    vid_low = 1; tick();
    check("idx1_addr", 32'(sys_addr), 32'h3FFA8);
    vid_low = 0; tick();

    // A held ack is one accept
    do_ack(2'b10, 5);
    check("held_ack_vid_idx", 32'(vid_idx), 32'h2);

    // Wrap: run up to the last block, then one more
    for (int i = 0; i < 3069; i++) do_ack(2'b10, 1);
    check("pre_wrap_vid_idx", 32'(vid_idx), 32'd3071);
    vid_low = 1; tick();
    check("idx3071_addr", 32'(sys_addr), 32'h39FD8);
    vid_low = 0; tick();
    do_ack(2'b10, 1);
    check("wrap_vid_idx", 32'(vid_idx), 32'h0);

    // Cache fill with a held ack 11
    do_ack(2'b11, 5);
    check("fill_vid_idx", 32'(vid_idx), 32'h0);
    base_vq = vq_cnt; base_fill = fill_cnt; base_drain = drain_cnt;
    sys_rd_data_valid = 1;
    #1 check("fill_we_comb", 32'(cache_fill_we), 32'h1);
    for (int i = 0; i < 128; i++) begin
      sys_dout = 16'($urandom);
      tick();
    end
    sys_rd_data_valid = 0;
    sys_wr_data_valid = 1;
    #1 check("drain_re_comb", 32'(cache_drain_re), 32'h1);
    repeat (4) tick();
    sys_wr_data_valid = 0;
    repeat (2) tick();
    check("fill_cnt", 32'(fill_cnt - base_fill), 32'd128);
    check("drain_cnt", 32'(drain_cnt - base_drain), 32'd4);
    check("fill_vq_cnt", 32'(vq_cnt - base_vq), 32'h0);

    // Reset after 5 video halfwords
    do_ack(2'b10, 1);
    check("mid_vid_idx", 32'(vid_idx), 32'h1);
    base_vq = vq_cnt; base_fill = fill_cnt;
    for (int i = 1; i <= 5; i++) begin
      sys_rd_data_valid = 1; sys_dout = 16'(16'h100 + i);
      tick();
    end
    rst = 1; sys_dout = 16'h0106;
    tick();
    rst = 0;
    for (int i = 7; i <= 10; i++) begin
      sys_dout = 16'(16'h100 + i);
      #1 check($sformatf("post_rst_fill_we%0d", i), 32'(cache_fill_we), 32'h0);
      tick();
    end
    sys_rd_data_valid = 0;
    repeat (2) tick();
    check("mid_rst_vq_cnt", 32'(vq_cnt - base_vq), 32'd2);
    check("mid_rst_word0", vq_log[base_vq], 32'h01020101);
    check("mid_rst_word1", vq_log[base_vq + 1], 32'h01040103);
    check("mid_rst_fill_cnt", 32'(fill_cnt - base_fill), 32'h0);
    check("mid_rst_vid_idx", 32'(vid_idx), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
